hist_mem_arbiter: RTL and testbench

Round-robin arbiter sharing one single-port histogram/CDF SRAM among the three equalization stages: requester 0 is the input histogram stage, 1 is the CDF stage, 2 is the output stage. It grants at most one access per cycle, registers the winning command onto the memory port and routes read data back to the originating requester with a valid strobe. It sits between the stage tops and the shared memory in the top level, next to the phase controller.

---
 rtl/hist_arb_pkg.sv | 43 ++++
 rtl/hist_mem_arbiter_rr_pick3.sv | 51 +++++
 rtl/hist_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_hist_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_arb_pkg.sv
// Shared definitions for the histogram-memory arbiter.
// Contents: requester count, requester ids, read-tag struct, and small id
// helpers (round-robin successor and id-to-one-hot decode).
package hist_arb_pkg;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  localparam logic [ID_W-1:0] REQ_INPUT  = 2'd0;
  localparam logic [ID_W-1:0] REQ_CDF    = 2'd1;
  localparam logic [ID_W-1:0] REQ_OUTPUT = 2'd2;

  // One read-tag pipeline entry: the requester awaiting data.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // Successor in round-robin order; 2 wraps to 0, the unused code 3 maps to 0.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] nxt;
    case (id)
      REQ_INPUT:  nxt = REQ_CDF;
      REQ_CDF:    nxt = REQ_OUTPUT;
      REQ_OUTPUT: nxt = REQ_INPUT;
      default:    nxt = REQ_INPUT;
    endcase
    return nxt;
  endfunction

  // Decode a requester id to a one-hot vector.
  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    case (id)
      REQ_INPUT:  oh = 3'b001;
      REQ_CDF:    oh = 3'b010;
      REQ_OUTPUT: oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/hist_mem_arbiter_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin priority picker.
// Ports: req_i (requests), ptr_i (highest-priority id) ->
//        gnt_o (one-hot grant), idx_o (granted id), any_o (some grant).
module rr_pick3
  import hist_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] ord0_s;
  logic [ID_W-1:0] ord1_s;
  logic [ID_W-1:0] ord2_s;

  // Search order starting at the pointer; an illegal pointer behaves as 0.
  always_comb begin
    if (ptr_i == 2'd3) begin
      ord0_s = REQ_INPUT;
    end else begin
      ord0_s = ptr_i;
    end
    ord1_s = next_id(ord0_s);
    ord2_s = next_id(ord1_s);
  end

  // First requester in search order wins.
  always_comb begin
    if (req_i[ord0_s]) begin
      idx_o = ord0_s;
      any_o = 1'b1;
    end else if (req_i[ord1_s]) begin
      idx_o = ord1_s;
      any_o = 1'b1;
    end else if (req_i[ord2_s]) begin
      idx_o = ord2_s;
      any_o = 1'b1;
    end else begin
      idx_o = REQ_INPUT;
      any_o = 1'b0;
    end
    if (any_o) begin
      gnt_o = id_onehot(idx_o);
    end else begin
      gnt_o = 3'b000;
    end
  end

endmodule

// File: rtl/hist_mem_arbiter.sv
// hist_mem_arbiter: round-robin arbiter giving the input-histogram (0), CDF (1)
// and output (2) stages access to one single-port histogram SRAM.
// Ports: clock/reset (async, active-high); req/we/addr/wdata per requester;
//        gnt (combinational one-hot grant); rvalid/rdata (read return);
//        mem_en/mem_we/mem_addr/mem_wdata (registered SRAM command);
//        mem_rdata (SRAM data, RD_LAT cycles after a read command).
// Option: define ARB_LOCK_EN to add the lock port; a granted requester that
//         holds lock keeps the pointer so it wins again (atomic RMW).
module hist_mem_arbiter
  import hist_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
`ifdef ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]        lock
`endif
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  tag_t              tag_q [0:RD_LAT];
  tag_t              tag0_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               pick_any_s;

  rr_pick3 u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s),
    .any_o (pick_any_s)
  );

  assign gnt = pick_gnt_s;

  // Next memory command, pointer and read tag for the winning requester.
  always_comb begin
    if (pick_any_s) begin
      en_d    = 1'b1;
      we_d    = we[pick_idx_s];
      addr_d  = addr[pick_idx_s*ADDR_W +: ADDR_W];
      wdata_d = wdata[pick_idx_s*DATA_W +: DATA_W];
`ifdef ARB_LOCK_EN
      if (lock[pick_idx_s]) begin
        ptr_d = pick_idx_s;
      end else begin
        ptr_d = next_id(pick_idx_s);
      end
`else
      ptr_d   = next_id(pick_idx_s);
`endif
      tag0_d.valid = ~we[pick_idx_s];
      tag0_d.id    = pick_idx_s;
    end else begin
      en_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ptr_d   = ptr_q;
      tag0_d  = '0;
    end
  end

  // Pointer, memory command and read-tag pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= 2'd0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int s = 0; s <= RD_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tag_q[0] <= tag0_d;
      for (int s = 1; s <= RD_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // The last tag stage lines up with the SRAM data for that read.
  always_comb begin
    if (tag_q[RD_LAT].valid) begin
      rvalid = id_onehot(tag_q[RD_LAT].id);
    end else begin
      rvalid = 3'b000;
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_hist_mem_arbiter.sv
// Self-checking bench for hist_mem_arbiter: directed scenarios plus a random
// run, all compared against a behavioural model of the arbitration rules.
module tb_hist_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
`ifdef ARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic clock, reset;
  logic [2:0] req, we, gnt, rvalid;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
`ifdef ARB_LOCK_EN
  logic [2:0] lock_s;
`endif

  int checks = 0;
  int errors = 0;

  hist_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_LOCK_EN
    , .lock(lock_s)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM behavioural model with RD_LAT read latency.
  logic [DATA_W-1:0] sram [0:255];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clock) begin
    if (mem_en && !mem_we) rd_pipe[0] <= sram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model state.
  int m_ptr, cyc;
  logic m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wd;
  logic [DATA_W-1:0] ref_mem [0:255];
  bit sched_v [0:7];
  int sched_id [0:7];
  logic [DATA_W-1:0] sched_d [0:7];

  // Observed / expected values for the cycle just applied.
  logic [2:0] o_gnt, e_gnt, o_rv, e_rv;
  logic [DATA_W-1:0] o_rd, e_rd, o_mwd, e_mwd;
  logic o_men, e_men, o_mwe, e_mwe;
  logic [ADDR_W-1:0] o_maddr, e_maddr;

  function automatic int model_pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return 3;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
    for (int i = 0; i < 8; i++) sched_v[i] = 1'b0;
  endtask

  // Drive one cycle (called just after a falling edge), record observed and
  // expected outputs, then advance the model across the rising edge.
  task automatic apply_cycle(input logic [2:0] r, input logic [2:0] w,
                             input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                             input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                             input logic [2:0] lk);
    int k, slot;
    logic [7:0] a [3];
    logic [15:0] d [3];
    a[0] = a0; a[1] = a1; a[2] = a2; d[0] = d0; d[1] = d1; d[2] = d2;
    req = r; we = w; addr = {a2, a1, a0}; wdata = {d2, d1, d0};
`ifdef ARB_LOCK_EN
    lock_s = lk;
`endif
    if (reset) model_reset();
    k = model_pick(r, m_ptr);
    e_gnt = (k < 3) ? (3'b001 << k) : 3'b000;
    slot = cyc % 8;
    e_rv = sched_v[slot] ? (3'b001 << sched_id[slot]) : 3'b000;
    e_rd = sched_d[slot];
    e_men = m_en; e_mwe = m_we; e_maddr = m_addr; e_mwd = m_wd;
    #1;
    o_gnt = gnt; o_rv = rvalid; o_rd = rdata;
    o_men = mem_en; o_mwe = mem_we; o_maddr = mem_addr; o_mwd = mem_wdata;
    @(posedge clock);
    sched_v[slot] = 1'b0;
    if (reset) begin
      model_reset();
    end else if (k < 3) begin
      m_en = 1'b1; m_we = w[k]; m_addr = a[k]; m_wd = d[k];
      if (w[k]) begin
        ref_mem[a[k]] = d[k];
      end else begin
        sched_v[(cyc + 1 + RD_LAT) % 8] = 1'b1;
        sched_id[(cyc + 1 + RD_LAT) % 8] = k;
        sched_d[(cyc + 1 + RD_LAT) % 8] = ref_mem[a[k]];
      end
      m_ptr = (LOCK_BUILD && lk[k]) ? k : (k + 1) % 3;
    end else begin
      m_en = 1'b0; m_we = 1'b0;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle();
    apply_cycle(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 3'b000);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply_cycle(3'b100, 3'b000, 8'h11, 8'h22, 8'h33, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b100) begin errors++; $display("FAIL reset_gnt got %b exp %b", o_gnt, 3'b100); end
    checks++; if ({o_men, o_mwe} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we got %b exp 00", {o_men, o_mwe}); end
    checks++; if (o_maddr !== 8'h00 || o_mwd !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr_wdata got %h/%h exp 00/0000", o_maddr, o_mwd); end
    checks++; if (o_rv !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", o_rv); end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_single_read();
    sram[8'h2A] = 16'h1234; ref_mem[8'h2A] = 16'h1234;
    apply_cycle(3'b010, 3'b000, 8'h00, 8'h2A, 8'h00, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got %b exp 010", o_gnt); end
    for (int j = 1; j <= RD_LAT + 1; j++) begin
      idle();
      if (j == 1) begin
        checks++; if (o_men !== 1'b1 || o_mwe !== 1'b0 || o_maddr !== 8'h2A) begin
          errors++; $display("FAIL single_cmd got en%b we%b a%h exp en1 we0 a2a", o_men, o_mwe, o_maddr); end
      end
      if (j == RD_LAT + 1) begin
        checks++; if (o_rv !== 3'b010 || o_rd !== 16'h1234) begin
          errors++; $display("FAIL single_resp got %b/%h exp 010/1234", o_rv, o_rd); end
      end else begin
        checks++; if (o_rv !== 3'b000) begin errors++; $display("FAIL single_early_rvalid got %b exp 000", o_rv); end
      end
    end
  endtask

  task automatic test_contention();
    int cnt [3];
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      apply_cycle(3'b111, 3'b000, 8'($urandom), 8'($urandom), 8'($urandom), 16'h0, 16'h0, 16'h0, 3'b000);
      checks++; if (o_gnt !== (3'b001 << (i % 3))) begin
        errors++; $display("FAIL contention_gnt cycle %0d got %b exp %b", i, o_gnt, 3'b001 << (i % 3)); end
      checks++; if (o_rv !== e_rv || (e_rv != 3'b000 && o_rd !== e_rd)) begin
        errors++; $display("FAIL contention_resp got %b/%h exp %b/%h", o_rv, o_rd, e_rv, e_rd); end
      for (int q = 0; q < 3; q++) if (o_gnt[q]) cnt[q]++;
    end
    checks++; if (cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 3) begin
      errors++; $display("FAIL contention_counts got %0d/%0d/%0d exp 3/3/3", cnt[0], cnt[1], cnt[2]); end
    for (int j = 0; j <= RD_LAT; j++) begin
      idle();
      checks++; if (o_rv !== e_rv || (e_rv != 3'b000 && o_rd !== e_rd)) begin
        errors++; $display("FAIL contention_drain got %b/%h exp %b/%h", o_rv, o_rd, e_rv, e_rd); end
    end
  endtask

  task automatic test_write_then_read();
    apply_cycle(3'b001, 3'b001, 8'h05, 8'h00, 8'h00, 16'hBEEF, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b001) begin errors++; $display("FAIL raw_wgnt got %b exp 001", o_gnt); end
    apply_cycle(3'b100, 3'b000, 8'h00, 8'h00, 8'h05, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b100) begin errors++; $display("FAIL raw_rgnt got %b exp 100", o_gnt); end
    checks++; if (o_men !== 1'b1 || o_mwe !== 1'b1 || o_maddr !== 8'h05 || o_mwd !== 16'hBEEF) begin
      errors++; $display("FAIL raw_wcmd got en%b we%b a%h d%h exp en1 we1 a05 dbeef", o_men, o_mwe, o_maddr, o_mwd); end
    for (int j = 1; j <= RD_LAT + 1; j++) begin
      idle();
      if (j == 1) begin
        checks++; if (o_men !== 1'b1 || o_mwe !== 1'b0) begin
          errors++; $display("FAIL raw_rcmd got en%b we%b exp en1 we0", o_men, o_mwe); end
      end
      if (j == RD_LAT + 1) begin
        checks++; if (o_rv !== 3'b100 || o_rd !== 16'hBEEF) begin
          errors++; $display("FAIL raw_resp got %b/%h exp 100/beef", o_rv, o_rd); end
      end
    end
  endtask

  task automatic test_ptr_wrap();
    apply_cycle(3'b100, 3'b000, 8'h01, 8'h02, 8'h03, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b100) begin errors++; $display("FAIL wrap_first got %b exp 100", o_gnt); end
    apply_cycle(3'b101, 3'b000, 8'h04, 8'h05, 8'h06, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b001) begin errors++; $display("FAIL wrap_second got %b exp 001", o_gnt); end
    for (int j = 0; j <= RD_LAT + 1; j++) begin
      idle();
      checks++; if (o_rv !== e_rv || (e_rv != 3'b000 && o_rd !== e_rd)) begin
        errors++; $display("FAIL wrap_drain got %b/%h exp %b/%h", o_rv, o_rd, e_rv, e_rd); end
    end
  endtask

  task automatic test_reset_mid_read();
    apply_cycle(3'b010, 3'b000, 8'h00, 8'h10, 8'h00, 16'h0, 16'h0, 16'h0, 3'b000);
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      idle();
      checks++; if (o_men !== 1'b0 || o_rv !== 3'b000) begin
        errors++; $display("FAIL midreset_hold got en%b rv%b exp en0 rv000", o_men, o_rv); end
    end
    reset = 1'b0;
    for (int j = 0; j < RD_LAT + 2; j++) begin
      idle();
      checks++; if (o_rv !== 3'b000 || o_men !== 1'b0) begin
        errors++; $display("FAIL midreset_after got rv%b en%b exp rv000 en0", o_rv, o_men); end
    end
    apply_cycle(3'b111, 3'b111, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b001) begin errors++; $display("FAIL midreset_ptr got %b exp 001", o_gnt); end
    idle();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    pulse_reset();
    for (int j = 0; j < 3; j++) begin
      apply_cycle(3'b011, 3'b000, 8'h07, 8'h08, 8'h00, 16'h0, 16'h0, 16'h0, 3'b001);
      checks++; if (o_gnt !== 3'b001) begin errors++; $display("FAIL lock_hold cycle %0d got %b exp 001", j, o_gnt); end
    end
    apply_cycle(3'b010, 3'b000, 8'h07, 8'h08, 8'h00, 16'h0, 16'h0, 16'h0, 3'b000);
    checks++; if (o_gnt !== 3'b010) begin errors++; $display("FAIL lock_release got %b exp 010", o_gnt); end
    for (int j = 0; j <= RD_LAT; j++) idle();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply_cycle(3'($urandom), 3'($urandom),
                  8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom), 16'($urandom), 3'b000);
      checks++; if (o_gnt !== e_gnt) begin errors++; $display("FAIL rand_gnt cycle %0d got %b exp %b", i, o_gnt, e_gnt); end
      checks++; if (o_rv !== e_rv || (e_rv != 3'b000 && o_rd !== e_rd)) begin
        errors++; $display("FAIL rand_resp cycle %0d got %b/%h exp %b/%h", i, o_rv, o_rd, e_rv, e_rd); end
      checks++; if (o_men !== e_men || o_mwe !== e_mwe || (e_men && (o_maddr !== e_maddr || o_mwd !== e_mwd))) begin
        errors++; $display("FAIL rand_cmd cycle %0d got %b%b %h %h exp %b%b %h %h", i,
                           o_men, o_mwe, o_maddr, o_mwd, e_men, e_mwe, e_maddr, e_mwd); end
    end
    for (int j = 0; j <= RD_LAT; j++) begin
      idle();
      checks++; if (o_rv !== e_rv || (e_rv != 3'b000 && o_rd !== e_rd)) begin
        errors++; $display("FAIL rand_drain got %b/%h exp %b/%h", o_rv, o_rd, e_rv, e_rd); end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef ARB_LOCK_EN
    lock_s = '0;
`endif
    cyc = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'(i * 3 + 16'h0100);
      ref_mem[i] = 16'(i * 3 + 16'h0100);
    end
    @(negedge clock);
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_ptr_wrap();
    test_reset_mid_read();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
